// File: rtl/pb_soc_uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, default sizes
// and the bit layout of the FIFO status byte.
package pb_soc_uart_pkg;

  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned STAT_OVERFLOW  = 7;
  localparam int unsigned STAT_BUSY      = 6;
  localparam int unsigned STAT_FULL      = 5;
  localparam int unsigned STAT_EMPTY     = 4;
  localparam int unsigned STAT_COUNT_MSB = 3;

  // The empty bit follows the 4-bit count field, so it also reads 1 when the
  // FIFO holds exactly 16 entries (count field wraps to 0).
  function automatic logic [7:0] pack_status(input logic       overflow,
                                             input logic       busy,
                                             input logic       full,
                                             input logic [3:0] count_field);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_OVERFLOW]      = overflow;
    s[STAT_BUSY]          = busy;
    s[STAT_FULL]          = full;
    s[STAT_EMPTY]         = (count_field == 4'd0);
    s[STAT_COUNT_MSB:0]   = count_field;
    return s;
  endfunction

endpackage

// File: rtl/pb_soc_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read, occupancy count and
// full/empty flags. Pushes when full and pops when empty are ignored.
module pb_soc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head is read combinationally so the consumer can load it on the pop edge.
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pb_soc_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser paced by a
// programmable prescaler with OVERSAMPLE ticks per bit.
module pb_soc_uart_tx
  import pb_soc_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       baud_enable_i,
  input  logic [7:0] baud_count_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_write_i,
  input  logic       clear_overflow_i,
  output logic       tx_o,
  output logic [7:0] fifo_status_o,
  output logic       tx_done_o
);

  localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  tx_state_e     state_reg, state_next;
  logic [7:0]    pre_cnt_reg, pre_cnt_next;
  logic [7:0]    baud_reg, baud_next;
  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          done_reg, done_next;
  logic          ovf_reg, ovf_next;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          tick;
  logic          bit_end;

  pb_soc_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (tx_data_i),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Full is judged before the edge, so a write on a pop edge is still dropped.
  assign fifo_push = tx_write_i && !fifo_full;
  assign tick      = (pre_cnt_reg == baud_reg);
  assign bit_end   = tick && (tick_cnt_reg == TW'(OVERSAMPLE - 1));

  always_comb begin
    state_next    = state_reg;
    pre_cnt_next  = pre_cnt_reg;
    baud_next     = baud_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    done_next     = 1'b0;
    fifo_pop      = 1'b0;

    if (state_reg != ST_IDLE) begin
      if (tick) begin
        pre_cnt_next  = 8'd0;
        baud_next     = baud_count_i;
        tick_cnt_next = bit_end ? '0 : tick_cnt_reg + TW'(1);
      end else begin
        pre_cnt_next  = pre_cnt_reg + 8'd1;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (baud_enable_i && !fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_next    = fifo_head;
          tx_next       = 1'b0;
          pre_cnt_next  = 8'd0;
          baud_next     = baud_count_i;
          tick_cnt_next = '0;
          bit_idx_next  = 3'd0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_next    = shift_reg[0];
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == 3'd7) begin
            tx_next    = 1'b1;
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase

    // Losing the enable mid-frame abandons the byte already popped.
    if (state_reg != ST_IDLE && !baud_enable_i) begin
      state_next = ST_IDLE;
      tx_next    = 1'b1;
      done_next  = 1'b0;
    end

    if (tx_write_i && fifo_full) begin
      ovf_next = 1'b1;
    end else if (clear_overflow_i) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = ovf_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg    <= ST_IDLE;
      pre_cnt_reg  <= 8'd0;
      baud_reg     <= 8'd0;
      tick_cnt_reg <= '0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pre_cnt_reg  <= pre_cnt_next;
      baud_reg     <= baud_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign tx_o          = tx_reg;
  assign tx_done_o     = done_reg;
  assign fifo_status_o = pack_status(ovf_reg, state_reg != ST_IDLE, fifo_full,
                                     4'(fifo_count));

endmodule

// File: tb/tb_pb_soc_uart_tx.sv
// Bench for pb_soc_uart_tx: directed scenarios plus random traffic, every
// cycle compared against a frame-position model of the serial line and FIFO.
module tb_pb_soc_uart_tx;

  localparam int DEPTH = 16;
  localparam int OSR   = 16;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] baud;
  logic [7:0] data;
  logic       wr;
  logic       clr;
  logic       tx_o;
  logic [7:0] fifo_status_o;
  logic       tx_done_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frames   = 0;

  // Model: queue of pending bytes plus position (in clocks) inside the frame.
  logic [7:0] q[$];
  bit         m_active;
  int         m_pos;
  int         m_len;
  logic [7:0] m_cur;
  bit         m_ovf;
  bit         m_done;

  pb_soc_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .OVERSAMPLE (OSR)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .baud_enable_i    (en),
    .baud_count_i     (baud),
    .tx_data_i        (data),
    .tx_write_i       (wr),
    .clear_overflow_i (clr),
    .tx_o             (tx_o),
    .fifo_status_o    (fifo_status_o),
    .tx_done_o        (tx_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / m_len;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_status();
    int n;
    logic [3:0] f;
    n = q.size();
    f = 4'(n % 16);
    return {m_ovf, m_active, (n == DEPTH), (f == 4'd0), f};
  endfunction

  task automatic model_edge();
    bit was_full;
    if (!rst_n) begin
      q.delete();
      m_active = 0;
      m_ovf    = 0;
      m_done   = 0;
      return;
    end
    was_full = (q.size() == DEPTH);
    m_done   = 0;
    if (m_active) begin
      if (!en) begin
        m_active = 0;
        $display("abort byte %02h at frame clock %0d", m_cur, m_pos);
      end else begin
        m_pos++;
        if (m_pos == 10 * m_len) begin
          m_active = 0;
          m_done   = 1;
          frames++;
          $display("frame %0d byte %02h sent, bit length %0d clocks", frames, m_cur, m_len);
        end
      end
    end else if (en && q.size() > 0) begin
      m_cur    = q.pop_front();
      m_active = 1;
      m_pos    = 0;
      m_len    = OSR * (int'(baud) + 1);
    end
    if (wr && was_full) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (wr && !was_full) q.push_back(data);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("tx", tx_o, exp_tx());
    check("done", tx_done_o, m_done);
    check("status", fifo_status_o, exp_status());
  endtask

  initial begin
    logic [9:0] pat;
    int         done_cnt;
    rst_n = 1'b0; en = 1'b0; baud = 8'd0; data = 8'd0; wr = 1'b0; clr = 1'b0;
    m_active = 0; m_pos = 0; m_len = OSR; m_cur = 8'h00; m_ovf = 0; m_done = 0;
    repeat (2) tick();
    check("reset_status", fifo_status_o, 8'h10);
    check("reset_tx", tx_o, 1);
    rst_n = 1'b1;
    tick();

    // Single A5 frame at B=0.
    $display("scenario: A5 at B=0");
    en = 1'b1; wr = 1'b1; data = 8'hA5;
    tick();
    wr = 1'b0;
    tick();
    pat = {1'b1, 8'hA5, 1'b0};
    done_cnt = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 16; c++) begin
        if (c == 8) check("a5_bit", tx_o, pat[b]);
        tick();
        if (tx_done_o) done_cnt++;
      end
    end
    repeat (3) begin
      tick();
      if (tx_done_o) done_cnt++;
    end
    check("a5_done_count", done_cnt, 1);

    // Two queued bytes at B=3, one idle clock between frames.
    $display("scenario: 00,FF at B=3");
    en = 1'b0; baud = 8'd3;
    wr = 1'b1; data = 8'h00; tick();
    data = 8'hFF; tick();
    wr = 1'b0;
    check("two_queued", fifo_status_o, 8'h02);
    en = 1'b1;
    tick();
    check("f1_start", fifo_status_o, 8'h41);
    repeat (639) tick();
    tick();
    check("f1_done", tx_done_o, 1);
    check("gap_status", fifo_status_o, 8'h01);
    tick();
    check("f2_start_tx", tx_o, 0);
    check("f2_start", fifo_status_o, 8'h50);
    repeat (640) tick();
    check("f2_done", tx_done_o, 1);
    check("f2_idle", fifo_status_o, 8'h10);
    tick();

    // Fill with the enable off, then overflow and clear.
    $display("scenario: overflow");
    en = 1'b0; baud = 8'd0;
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; data = 8'($urandom);
      tick();
    end
    check("full16", fifo_status_o, 8'h30);
    data = 8'($urandom);
    tick();
    wr = 1'b0;
    check("overflow17", fifo_status_o, 8'hB0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ovf_clear", fifo_status_o, 8'h30);

    // Write collides with the pop edge while full.
    $display("scenario: write on pop edge while full");
    en = 1'b1; wr = 1'b1; data = 8'h5A;
    tick();
    wr = 1'b0;
    check("pop_write_full", fifo_status_o, 8'hCF);

    // Abort in data bit 3, then reset mid-frame.
    $display("scenario: abort and mid-frame reset");
    repeat (72) tick();
    en = 1'b0;
    tick();
    check("abort_tx", tx_o, 1);
    check("abort_done", tx_done_o, 0);
    check("abort_status", fifo_status_o, 8'h8F);
    done_cnt = 0;
    repeat (5) begin
      tick();
      if (tx_done_o) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1;
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_status", fifo_status_o, 8'h10);
    check("rst_mid_tx", tx_o, 1);
    rst_n = 1'b1;
    tick();

    // Random traffic.
    $display("scenario: random traffic");
    baud = 8'($urandom_range(0, 1));
    for (int i = 0; i < 3000; i++) begin
      wr   = ($urandom_range(0, 9) == 0);
      data = 8'($urandom);
      clr  = ($urandom_range(0, 49) == 0);
      en   = ($urandom_range(0, 599) != 0);
      if (!m_active && $urandom_range(0, 9) == 0) baud = 8'($urandom_range(0, 2));
      tick();
    end
    wr = 1'b0; clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
